// File: rtl/bm_lpm_alu_sched.sv
// Round-robin scheduler sharing one 32-bit add/sub/compare-select ALU among four requesters.
// Latency: grant one cycle after capture, resp_valid one cycle later (two with BM_LPM_SCHED_OUT_REG_EN).
// Backpressure: the result is held in RESP until resp_ready; new requests wait while busy.
module bm_lpm_alu_sched #(
  parameter int BITS = 32,
  parameter int CNTW = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        req_valid,
  input  logic [11:0]       req_op,
  input  logic [4*BITS-1:0] req_a,
  input  logic [4*BITS-1:0] req_b,
  output logic [3:0]        req_grant,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_id,
  output logic [BITS-1:0]   resp_data,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    RESP  = 2'd2
`ifdef BM_LPM_SCHED_OUT_REG_EN
    ,
    EXEC2 = 2'd3
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_last;
  logic [1:0]        r_id;
  logic [2:0]        r_op;
  logic [BITS-1:0]   r_a;
  logic [BITS-1:0]   r_b;
  logic [3:0]        r_grant;
  logic              r_resp_valid;
  logic [1:0]        r_resp_id;
  logic [BITS-1:0]   r_resp_data;
  logic [CNTW-1:0]   r_count;

  logic              w_found;
  logic [1:0]        w_sel;
  logic [1:0]        w_idx;
  logic [BITS-1:0]   w_alu;
  logic [BITS-1:0]   w_res;
  logic              w_capture;
  logic              w_load;
  logic              w_accept;

`ifdef BM_LPM_SCHED_OUT_REG_EN
  logic [BITS-1:0]   r_alu;
  assign w_res = r_alu;
`else
  assign w_res = w_alu;
`endif

  // Round-robin pick: first requester after the last served one, wrapping mod 4.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Shared ALU on the latched operands; all compares unsigned, arithmetic wraps.
  always_comb begin
    w_alu = '0;
    case (r_op)
      3'd0:    w_alu = r_a + r_b;
      3'd1:    w_alu = r_a - r_b;
      3'd2:    w_alu = (r_a == r_b) ? r_a : r_b;
      3'd3:    w_alu = (r_a >= r_b) ? r_a : r_b;
      3'd4:    w_alu = (r_a >  r_b) ? r_a : r_b;
      3'd5:    w_alu = (r_a <= r_b) ? r_a : r_b;
      3'd6:    w_alu = (r_a <  r_b) ? r_a : r_b;
      default: w_alu = (r_a == r_b) ? (r_a + r_b) : (r_b - r_a);
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_load    = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_capture = 1'b1;
          w_next    = EXEC;
        end
      end
`ifdef BM_LPM_SCHED_OUT_REG_EN
      EXEC:  w_next = EXEC2;
      EXEC2: begin
        w_load = 1'b1;
        w_next = RESP;
      end
`else
      EXEC: begin
        w_load = 1'b1;
        w_next = RESP;
      end
`endif
      RESP: begin
        if (resp_ready) begin
          w_accept = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, grant pulse, response registers and completion counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last       <= 2'd3;
      r_id         <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_grant      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_count      <= '0;
`ifdef BM_LPM_SCHED_OUT_REG_EN
      r_alu        <= '0;
`endif
    end else begin
      r_grant <= '0;
      if (w_capture) begin
        r_grant <= 4'b0001 << w_sel;
        r_id    <= w_sel;
        r_op    <= req_op[3*w_sel +: 3];
        r_a     <= req_a[BITS*w_sel +: BITS];
        r_b     <= req_b[BITS*w_sel +: BITS];
      end
`ifdef BM_LPM_SCHED_OUT_REG_EN
      if (r_state == EXEC) r_alu <= w_alu;
`endif
      if (w_load) begin
        r_resp_valid <= 1'b1;
        r_resp_id    <= r_id;
        r_resp_data  <= w_res;
      end
      if (w_accept) begin
        r_resp_valid <= 1'b0;
        r_last       <= r_resp_id;
        r_count      <= r_count + CNTW'(1);
      end
    end
  end

  assign req_grant  = r_grant;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != IDLE);
  assign op_count   = r_count;

endmodule

// File: tb/tb_bm_lpm_alu_sched.sv
// Scoreboard bench for bm_lpm_alu_sched: expected grants/results queued at drive time, popped on output.
// Latency: checks grant at T+1 and result at T+2 (T+3 with BM_LPM_SCHED_OUT_REG_EN).
// Backpressure: holds resp_ready low for 10 cycles and checks the response is frozen.
module tb_bm_lpm_alu_sched;
  localparam int BITS = 32;
  localparam int CNTW = 4;
`ifdef BM_LPM_SCHED_OUT_REG_EN
  localparam int ISSUE = 4;
`else
  localparam int ISSUE = 3;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        req_valid;
  logic [11:0]       req_op;
  logic [4*BITS-1:0] req_a;
  logic [4*BITS-1:0] req_b;
  logic [3:0]        req_grant;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [BITS-1:0]   resp_data;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  bm_lpm_alu_sched #(.BITS(BITS), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_grant(req_grant), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [BITS+1:0] sb_q[$];
  logic [1:0]      gq[$];
  int cyc = 0;
  int n_grants = 0;
  int last_gcyc = -1;
  bit spacing_on = 1'b0;
  bit oneshot = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BITS-1:0] ref_alu(input logic [2:0] op, input logic [BITS-1:0] a,
                                              input logic [BITS-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return (a == b) ? a : b;
      3'd3:    return (a >= b) ? a : b;
      3'd4:    return (a > b) ? a : b;
      3'd5:    return (a <= b) ? a : b;
      3'd6:    return (a < b) ? a : b;
      default: return (a == b) ? (a + b) : (b - a);
    endcase
  endfunction

  // Per-cycle observation at the falling edge.
  task automatic monitor();
    logic [1:0]      id;
    logic [BITS+1:0] e;
    cyc++;
    if (req_grant != 4'd0) begin
      check("grant_onehot", $countones(req_grant), 1);
      n_grants++;
      if (spacing_on && last_gcyc >= 0) check("grant_spacing", cyc - last_gcyc, ISSUE);
      last_gcyc = cyc;
      if (gq.size() == 0) check("grant_extra", req_grant, 0);
      else begin
        id = gq.pop_front();
        check("grant_id", req_grant, 4'b0001 << id);
      end
    end
    if (resp_valid && resp_ready) begin
      if (sb_q.size() == 0) check("resp_extra", resp_valid, 0);
      else begin
        e = sb_q.pop_front();
        check("resp_id", resp_id, e[BITS+1:BITS]);
        check("resp_data", resp_data, e[BITS-1:0]);
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    if (oneshot) req_valid = req_valid & ~req_grant;
  endtask

  task automatic drive(input int id, input logic [2:0] op, input logic [BITS-1:0] a,
                       input logic [BITS-1:0] b, input logic [BITS-1:0] exp);
    req_op[3*id +: 3]       = op;
    req_a[BITS*id +: BITS]  = a;
    req_b[BITS*id +: BITS]  = b;
    req_valid[id]           = 1'b1;
    gq.push_back(2'(id));
    sb_q.push_back({2'(id), exp});
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0 && !busy) break;
      step();
    end
    check("drain_resp", sb_q.size(), 0);
    check("drain_grant", gq.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [1:0]      h_id;
  logic [BITS-1:0] h_data;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'd1, 32'h0,        32'h1,        32'hFFFF_FFFF};
    vecs[1] = '{3'd7, 32'h3,        32'h3,        32'h6};
    vecs[2] = '{3'd7, 32'h5,        32'h2,        32'hFFFF_FFFD};
    vecs[3] = '{3'd6, 32'h8000_0000, 32'h1,       32'h1};
    vecs[4] = '{3'd2, 32'h4,        32'h4,        32'h4};
    vecs[5] = '{3'd2, 32'h4,        32'h9,        32'h9};
    vecs[6] = '{3'd3, 32'h9,        32'h9,        32'h9};
    vecs[7] = '{3'd4, 32'h3,        32'h3,        32'h3};
    vecs[8] = '{3'd5, 32'h8000_0000, 32'h7,       32'h7};
    vecs[9] = '{3'd0, 32'hFFFF_FFFF, 32'h2,       32'h1};

    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    step(); step(); step();
    check("rst_busy", busy, 0);
    check("rst_grant", req_grant, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_op_count", op_count, 0);
    reset = 1'b0;

    // Single request, exact latency.
    drive(0, 3'd0, 32'd5, 32'd7, 32'd12);
    step();
    check("t1_grant", req_grant, 4'b0001);
    step();
`ifdef BM_LPM_SCHED_OUT_REG_EN
    check("t1_valid_early", resp_valid, 0);
    step();
`endif
    check("t1_resp_valid", resp_valid, 1);
    check("t1_resp_id", resp_id, 0);
    check("t1_resp_data", resp_data, 32'd12);
    step();
    check("t1_op_count", op_count, 1);
    check("t1_valid_clear", resp_valid, 0);

    // Wrap and compare ops on requester 2.
    for (int i = 0; i < 10; i++) begin
      drive(2, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_drain(20);
    end
    check("ops_count", op_count, 4'd11);

    // All four continuously requesting from reset.
    do_reset();
    oneshot = 1'b0; spacing_on = 1'b1; last_gcyc = -1; n_grants = 0;
    for (int i = 0; i < 4; i++)
      drive(i, 3'(i), 32'd100 + 32'(i), 32'd50, ref_alu(3'(i), 32'd100 + 32'(i), 32'd50));
    gq.push_back(2'd0);
    sb_q.push_back({2'd0, ref_alu(3'd0, 32'd100, 32'd50)});
    for (int i = 0; i < 60; i++) begin
      if (n_grants == 5) break;
      step();
    end
    req_valid = '0;
    check("rr_grants", n_grants, 5);
    spacing_on = 1'b0; oneshot = 1'b1;
    wait_drain(30);

    // Backpressure with another requester pending.
    resp_ready = 1'b0;
    drive(1, 3'd1, 32'd9, 32'd4, 32'd5);
    drive(3, 3'd4, 32'h7000_0000, 32'h9000_0000, 32'h9000_0000);
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) break;
      step();
    end
    check("bp_valid_rise", resp_valid, 1);
    h_id = resp_id; h_data = resp_data;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid_hold", resp_valid, 1);
      check("bp_id_hold", resp_id, h_id);
      check("bp_data_hold", resp_data, h_data);
      check("bp_no_grant", req_grant, 0);
    end
    resp_ready = 1'b1;
    wait_drain(40);

    // Reset during EXEC discards the operation and restarts priority at 0.
    oneshot = 1'b0;
    drive(1, 3'd0, 32'd1, 32'd1, 32'd2);
    step();
    check("rx_grant", req_grant, 4'b0010);
    reset = 1'b1;
    step();
    check("rx_busy", busy, 0);
    check("rx_resp_valid", resp_valid, 0);
    check("rx_op_count", op_count, 0);
    void'(sb_q.pop_back());
    reset = 1'b0;
    drive(0, 3'd3, 32'd8, 32'd2, 32'd8);
    drive(1, 3'd0, 32'd1, 32'd1, 32'd2);
    oneshot = 1'b1;
    wait_drain(30);
    check("rx_count", op_count, 2);

    // Counter wrap with CNTW=4.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(i % 4, 3'd0, 32'(i), 32'd1, 32'(i) + 32'd1);
      wait_drain(20);
    end
    check("wrap_count", op_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
